mem_responder: RTL and testbench

Responder end of the memory bus: a 32x8 synchronous memory with a registered read port, a self-clearing engine and access-error reporting. It sits opposite the memory test initiator and accepts single-cycle `read`/`write` strobes with `addr`/`data_in`, returning `data_out`. An internal written-map makes reads deterministic after reset without resetting the array.

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Purpose : responder end of the memory bus; 2**ADDR_WIDTH x DATA_WIDTH sync RAM with written-map and clear engine.
// Latency : reads return one cycle after the sampling edge; writes land at the sampling edge.
// Backpr. : none; accesses arriving while the clear engine runs (or read+write together) are refused via err.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   read, write       single-cycle access strobes, addr / data_in qualify them
//   clear             starts the clear-all engine (only looked at when idle)
//   data_out          last successful read result; held otherwise
//   rd_valid, uninit  one-cycle read pulse, and "location never written since reset" qualifier
//   busy, err         clear engine running; one-cycle refused-access pulse
module mem_responder #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  uninit,
    output logic                  busy,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;

    // Array is deliberately not reset; wmap makes reads deterministic instead.
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]       wmap;

    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic                   rd_en;
    logic                   refuse;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data_in;
        rd_en     = 1'b0;
        refuse    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    // clear wins; any access in the same cycle is dropped
                    state_d = CLEAR;
                    cnt_d   = '0;
                    refuse  = read | write;
                end else if (read && write) begin
                    refuse = 1'b1;
                end else if (write) begin
                    mem_we = 1'b1;
                end else if (read) begin
                    rd_en = 1'b1;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                refuse    = read | write;
                // terminate on the last location, not on wrap to zero
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wmap     <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            uninit   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_valid <= rd_en;
            err      <= refuse;
            if (mem_we) begin
                wmap[mem_waddr] <= 1'b1;
            end
            if (rd_en) begin
                data_out <= wmap[addr] ? mem[addr] : '0;
                uninit   <= ~wmap[addr];
            end
        end
    end

    // A reset edge blocks the array write, so an aborted clear keeps only what it finished.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       clear = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       uninit;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .clear    (clear),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .uninit   (uninit),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [32];
    bit         m_wr  [32];
    int         m_clear_left = 0;   // cycles of clearing still to do
    logic [7:0] m_dout = '0;
    bit         m_rv = 0, m_un = 0, m_err = 0, m_busy = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_wr[i] = 0;
            m_clear_left = 0;
            m_dout = '0; m_rv = 0; m_un = 0; m_err = 0;
        end else begin
            m_rv  = 0;
            m_err = 0;
            if (m_clear_left > 0) begin
                int idx;
                idx = 32 - m_clear_left;
                m_mem[idx] = 8'h00;
                m_wr[idx]  = 1;
                m_clear_left--;
                m_err = read | write;
            end else if (clear) begin
                m_clear_left = 32;
                m_err = read | write;
            end else if (read && write) begin
                m_err = 1;
            end else if (write) begin
                m_mem[addr] = data_in;
                m_wr[addr]  = 1;
            end else if (read) begin
                m_dout = m_wr[addr] ? m_mem[addr] : 8'h00;
                m_un   = !m_wr[addr];
                m_rv   = 1;
            end
        end
        m_busy = (m_clear_left > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rv});
            chk("uninit",   {31'd0, uninit},   {31'd0, m_un});
            chk("busy",     {31'd0, busy},     {31'd0, m_busy});
            chk("err",      {31'd0, err},      {31'd0, m_err});
        end
    end

    // Apply one cycle of stimulus; called and returns at a falling edge,
    // so on return the outputs reflect the edge that sampled it.
    task automatic op(input logic r, input logic w, input logic c,
                      input logic [4:0] a, input logic [7:0] d);
        read = r; write = w; clear = c; addr = a; data_in = d;
        @(negedge clk);
        read = 1'b0; write = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // reset state, literal
        chk("rst_data_out", {24'd0, data_out}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);

        // read of never-written location
        op(1, 0, 0, 5'd5, 8'h00);
        chk("rd5_data", {24'd0, data_out}, 32'h00);
        chk("rd5_uninit", {31'd0, uninit}, 32'd1);
        chk("rd5_valid", {31'd0, rd_valid}, 32'd1);
        @(negedge clk);
        chk("rd5_valid_drop", {31'd0, rd_valid}, 32'd0);

        // fill and read back, back-to-back
        for (int i = 0; i < 32; i++) op(0, 1, 0, 5'(i), 8'hE9);
        for (int i = 0; i < 32; i++) begin
            op(1, 0, 0, 5'(i), 8'h00);
            chk("fill_data", {24'd0, data_out}, 32'hE9);
            chk("fill_uninit", {31'd0, uninit}, 32'd0);
        end
        chk("model_pin_fill", {24'd0, m_dout}, 32'hE9);

        // clear engine
        op(0, 1, 0, 5'd7, 8'h5A);
        op(0, 0, 1, 5'd0, 8'h00);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 32'd32);
        op(1, 0, 0, 5'd7, 8'h00);
        chk("clr_rd7_data", {24'd0, data_out}, 32'h00);
        chk("clr_rd7_uninit", {31'd0, uninit}, 32'd0);

        // simultaneous read+write is refused
        op(0, 1, 0, 5'd3, 8'h3C);
        op(1, 1, 0, 5'd3, 8'hFF);
        chk("rw_err", {31'd0, err}, 32'd1);
        chk("rw_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rw_data_held", {24'd0, data_out}, 32'h00);
        @(negedge clk);
        chk("rw_err_drop", {31'd0, err}, 32'd0);
        op(1, 0, 0, 5'd3, 8'h00);
        chk("rw_rd3_old", {24'd0, data_out}, 32'h3C);
        chk("model_pin_rw", {24'd0, m_dout}, 32'h3C);

        // access during clear, and clear with an access in the same cycle
        op(1, 0, 1, 5'd9, 8'h00);
        chk("clr_same_err", {31'd0, err}, 32'd1);
        op(1, 0, 0, 5'd2, 8'h00);
        chk("busy_rd_err", {31'd0, err}, 32'd1);
        chk("busy_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("busy_data_held", {24'd0, data_out}, 32'h3C);
        wait_not_busy();
        // access accepted on the first edge after busy falls
        op(1, 0, 0, 5'd3, 8'h00);
        chk("post_clr_rd3", {24'd0, data_out}, 32'h00);
        chk("post_clr_valid", {31'd0, rd_valid}, 32'd1);

        // reset in the middle of a clear
        op(0, 0, 1, 5'd0, 8'h00);
        repeat (9) @(negedge clk);
        chk("mid_clr_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_busy", {31'd0, busy}, 32'd0);
        op(1, 0, 0, 5'd0, 8'h00);
        chk("abort_rd0_data", {24'd0, data_out}, 32'h00);
        chk("abort_rd0_uninit", {31'd0, uninit}, 32'd1);
        op(1, 0, 0, 5'd20, 8'h00);
        chk("abort_rd20_uninit", {31'd0, uninit}, 32'd1);
        op(0, 1, 0, 5'd0, 8'h11);
        op(1, 0, 0, 5'd0, 8'h00);
        chk("abort_wr0_data", {24'd0, data_out}, 32'h11);
        chk("abort_wr0_uninit", {31'd0, uninit}, 32'd0);
        chk("model_pin_abort", {31'd0, m_un}, 32'd0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
